pnp_rom_walker: RTL

- Avalon-MM read master that walks the 1024x32 plug-and-play descriptor ROM.
- Validates the ROM magic, then follows the record chain until it finds a requested record ID.
- Reports the record's address and length, then streams the record payload out through a valid/ready interface.
- Sits between the PnP ROM slave port and the enumeration/config logic.

---
 rtl/pnp_rom_walker_if.sv | 36 +++
 rtl/pnp_rom_walker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pnp_rom_walker_if.sv
// Bundles the walker's control, ROM read-master and payload-stream signals.
// The master modport is the walker's view; slave is the ROM/consumer/controller side.
interface pnp_rom_walker_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [15:0]       target_id;
   logic              busy;
   logic              done;
   logic              found;
   logic [1:0]        err;
   logic [ADDR_W-1:0] rec_addr;
   logic [7:0]        rec_len;
   logic [ADDR_W-1:0] rom_address;
   logic              rom_chipselect;
   logic              rom_clken;
   logic [31:0]       rom_readdata;
   logic              pl_valid;
   logic [31:0]       pl_data;
   logic              pl_last;
   logic              pl_ready;

   modport master (
      input  start, target_id, rom_readdata, pl_ready,
      output busy, done, found, err, rec_addr, rec_len,
             rom_address, rom_chipselect, rom_clken,
             pl_valid, pl_data, pl_last
   );

   modport slave (
      output start, target_id, rom_readdata, pl_ready,
      input  busy, done, found, err, rec_addr, rec_len,
             rom_address, rom_chipselect, rom_clken,
             pl_valid, pl_data, pl_last
   );
endinterface

// File: rtl/pnp_rom_walker.sv
// Walks the PnP descriptor ROM: checks the magic word, follows the record chain to a
// requested ID, then streams that record's payload one word per valid/ready handshake.
module pnp_rom_walker #(
   parameter int          ADDR_W  = 10,
   parameter logic [15:0] MAGIC   = 16'h504E,
   parameter logic [15:0] END_ID  = 16'hFFFF,
   parameter int          MAX_REC = 64
) (
   input logic               clk,
   input logic               reset,
   pnp_rom_walker_if.master  bus
);
   localparam int HOP_W = $clog2(MAX_REC + 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_RD_MAGIC  = 4'd1;
   localparam logic [3:0] S_CAP_MAGIC = 4'd2;
   localparam logic [3:0] S_RD_HDR    = 4'd3;
   localparam logic [3:0] S_CAP_HDR   = 4'd4;
   localparam logic [3:0] S_RD_PL     = 4'd5;
   localparam logic [3:0] S_CAP_PL    = 4'd6;
   localparam logic [3:0] S_HOLD      = 4'd7;
   localparam logic [3:0] S_FIN       = 4'd8;

   logic [3:0]        state_q, state_d;
   logic [15:0]       target_q, target_d;
   logic [ADDR_W-1:0] hdr_q, hdr_d;
   logic [HOP_W-1:0]  hops_q, hops_d;
   logic [7:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
   logic [7:0]        rec_len_q, rec_len_d;
   logic              found_q, found_d;
   logic [1:0]        err_q, err_d;
   logic              pl_valid_q, pl_valid_d;
   logic [31:0]       pl_data_q, pl_data_d;
   logic              pl_last_q, pl_last_d;

   logic [15:0]       rd_id;
   logic [7:0]        rd_len;
   logic [ADDR_W:0]   next_hdr;
   logic [ADDR_W:0]   pl_addr;
   logic [HOP_W-1:0]  hops_inc;

   assign rd_id    = bus.rom_readdata[31:16];
   assign rd_len   = bus.rom_readdata[15:8];
   // One extra bit on both address sums so running off the end of the ROM is visible.
   assign next_hdr = {1'b0, hdr_q} + (ADDR_W+1)'(1) + {{(ADDR_W-7){1'b0}}, rd_len};
   assign pl_addr  = {1'b0, rec_addr_q} + (ADDR_W+1)'(1) + {{(ADDR_W-7){1'b0}}, idx_q};
   assign hops_inc = hops_q + HOP_W'(1);

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      hdr_d      = hdr_q;
      hops_d     = hops_q;
      idx_d      = idx_q;
      rec_addr_d = rec_addr_q;
      rec_len_d  = rec_len_q;
      found_d    = found_q;
      err_d      = err_q;
      pl_valid_d = pl_valid_q;
      pl_data_d  = pl_data_q;
      pl_last_d  = pl_last_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               target_d   = bus.target_id;
               found_d    = 1'b0;
               err_d      = 2'd0;
               rec_addr_d = '0;
               rec_len_d  = '0;
               state_d    = S_RD_MAGIC;
            end
         end
         S_RD_MAGIC: state_d = S_CAP_MAGIC;
         S_CAP_MAGIC: begin
            if (rd_id != MAGIC) begin
               err_d   = 2'd1;
               state_d = S_FIN;
            end else begin
               hdr_d   = ADDR_W'(1);
               hops_d  = '0;
               state_d = S_RD_HDR;
            end
         end
         S_RD_HDR: state_d = S_CAP_HDR;
         S_CAP_HDR: begin
            // END_ID is tested first so a target of END_ID can never match.
            if (rd_id == END_ID) begin
               state_d = S_FIN;
            end else if (rd_id == target_q) begin
               rec_addr_d = hdr_q;
               rec_len_d  = rd_len;
               found_d    = 1'b1;
               idx_d      = '0;
               state_d    = (rd_len == 8'd0) ? S_FIN : S_RD_PL;
            end else begin
               hops_d = hops_inc;
               if (hops_inc == HOP_W'(MAX_REC)) begin
                  err_d   = 2'd3;
                  state_d = S_FIN;
               end else if (next_hdr[ADDR_W]) begin
                  err_d   = 2'd2;
                  state_d = S_FIN;
               end else begin
                  hdr_d   = next_hdr[ADDR_W-1:0];
                  state_d = S_RD_HDR;
               end
            end
         end
         S_RD_PL: begin
            if (pl_addr[ADDR_W]) begin
               err_d   = 2'd2;
               state_d = S_FIN;
            end else begin
               state_d = S_CAP_PL;
            end
         end
         S_CAP_PL: begin
            pl_data_d  = bus.rom_readdata;
            pl_valid_d = 1'b1;
            pl_last_d  = (idx_q == rec_len_q - 8'd1);
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (bus.pl_ready) begin
               pl_valid_d = 1'b0;
               pl_last_d  = 1'b0;
               if (pl_last_q) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = S_RD_PL;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         target_q   <= '0;
         hdr_q      <= '0;
         hops_q     <= '0;
         idx_q      <= '0;
         rec_addr_q <= '0;
         rec_len_q  <= '0;
         found_q    <= 1'b0;
         err_q      <= 2'd0;
         pl_valid_q <= 1'b0;
         pl_data_q  <= '0;
         pl_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         hdr_q      <= hdr_d;
         hops_q     <= hops_d;
         idx_q      <= idx_d;
         rec_addr_q <= rec_addr_d;
         rec_len_q  <= rec_len_d;
         found_q    <= found_d;
         err_q      <= err_d;
         pl_valid_q <= pl_valid_d;
         pl_data_q  <= pl_data_d;
         pl_last_q  <= pl_last_d;
      end
   end

   always_comb begin
      bus.rom_address = '0;
      case (state_q)
         S_RD_HDR: bus.rom_address = hdr_q;
         S_RD_PL:  bus.rom_address = pl_addr[ADDR_W-1:0];
         default:  bus.rom_address = '0;
      endcase
   end

   assign bus.rom_chipselect = (state_q == S_RD_MAGIC) || (state_q == S_RD_HDR) ||
                               ((state_q == S_RD_PL) && !pl_addr[ADDR_W]);
   assign bus.rom_clken = 1'b1;
   assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FIN);
   assign bus.done      = (state_q == S_FIN);
   assign bus.found     = found_q;
   assign bus.err       = err_q;
   assign bus.rec_addr  = rec_addr_q;
   assign bus.rec_len   = rec_len_q;
   assign bus.pl_valid  = pl_valid_q;
   assign bus.pl_data   = pl_data_q;
   assign bus.pl_last   = pl_last_q;
endmodule
